// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter sharing one 32-bit ALU
// Grants one request per cycle and holds the result in a one-entry response register.

module alu32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  control,
  output logic [31:0] out,
  output logic        overflow,
  output logic        zero,
  output logic        negative,
  output logic        err
);
  always_comb begin
    out      = 32'd0;
    overflow = 1'b0;
    err      = 1'b0;
    case (control)
      3'd2: begin
        out      = a + b;
        overflow = (a[31] == b[31]) && (out[31] != a[31]);
      end
      3'd3: begin
        out      = a - b;
        overflow = (a[31] != b[31]) && (out[31] != a[31]);
      end
      3'd4: out = a & b;
      3'd5: out = a | b;
      3'd6: out = ~(a | b);
      3'd7: out = a ^ b;
      default: err = 1'b1;
    endcase
    // An illegal op reports no flags at all, so zero is masked by err.
    zero     = !err && (out == 32'd0);
    negative = out[31];
  end
endmodule

module alu_arbiter #(
  parameter bit FAIR = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_A,
  input  logic [31:0] req0_B,
  input  logic [2:0]  req0_control,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_A,
  input  logic [31:0] req1_B,
  input  logic [2:0]  req1_control,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_out,
  output logic        resp_overflow,
  output logic        resp_zero,
  output logic        resp_negative,
  output logic        resp_err,
  output logic [7:0]  busy_count
);
  logic        can_accept;
  logic        grant0;
  logic        grant1;
  logic        last_grant;
  logic        waiting;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_control;
  logic [31:0] alu_out;
  logic        alu_overflow;
  logic        alu_zero;
  logic        alu_negative;
  logic        alu_err;

  assign can_accept = !resp_valid || resp_ready;

  // last_grant holds the most recently granted requester; reset value 1 favours requester 0.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset && can_accept) begin
      if (req0_valid && req1_valid) begin
        if (FAIR && !last_grant) grant1 = 1'b1;
        else                     grant0 = 1'b1;
      end else if (req0_valid) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign alu_a       = grant1 ? req1_A       : req0_A;
  assign alu_b       = grant1 ? req1_B       : req0_B;
  assign alu_control = grant1 ? req1_control : req0_control;

  alu32 u_alu (
    .a        (alu_a),
    .b        (alu_b),
    .control  (alu_control),
    .out      (alu_out),
    .overflow (alu_overflow),
    .zero     (alu_zero),
    .negative (alu_negative),
    .err      (alu_err)
  );

  assign waiting = (req0_valid && !grant0) || (req1_valid && !grant1);

  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid    <= 1'b0;
      resp_id       <= 1'b0;
      resp_out      <= 32'd0;
      resp_overflow <= 1'b0;
      resp_zero     <= 1'b0;
      resp_negative <= 1'b0;
      resp_err      <= 1'b0;
      busy_count    <= 8'd0;
      last_grant    <= 1'b1;
    end else begin
      if (grant0 || grant1) begin
        resp_valid    <= 1'b1;
        resp_id       <= grant1;
        resp_out      <= alu_out;
        resp_overflow <= alu_overflow;
        resp_zero     <= alu_zero;
        resp_negative <= alu_negative;
        resp_err      <= alu_err;
        last_grant    <= grant1;
      end else if (resp_ready) begin
        resp_valid <= 1'b0;
      end
      if (waiting && busy_count != 8'hFF) busy_count <= busy_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter, round-robin and fixed-priority instances
module tb_alu_arbiter;
  typedef struct packed {
    logic        id;
    logic [31:0] out;
    logic        ov;
    logic        z;
    logic        n;
    logic        err;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, resp_ready = 1'b0;
  logic [31:0] req0_A = '0, req0_B = '0, req1_A = '0, req1_B = '0;
  logic [2:0]  req0_control = 3'd2, req1_control = 3'd2;
  logic        req0_ready, req1_ready, resp_valid, resp_id;
  logic        resp_overflow, resp_zero, resp_negative, resp_err;
  logic [31:0] resp_out;
  logic [7:0]  busy_count;
  logic        f_req0_ready, f_req1_ready, f_resp_valid, f_resp_id;
  logic        f_resp_overflow, f_resp_zero, f_resp_negative, f_resp_err;
  logic [31:0] f_resp_out;
  logic [7:0]  f_busy_count;
  resp_t       act;

  int    vectors = 0;
  int    miscompares = 0;
  resp_t sb[$];
  resp_t exp_r;
  logic  m_valid = 1'b0, m_last = 1'b1;
  int    m_busy = 0;

  always #5 clk = ~clk;

  assign act = {resp_id, resp_out, resp_overflow, resp_zero, resp_negative, resp_err};

  alu_arbiter #(.FAIR(1'b1)) dut (
    .clock(clk), .reset(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A), .req0_B(req0_B),
    .req0_control(req0_control),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A), .req1_B(req1_B),
    .req1_control(req1_control),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_out(resp_out),
    .resp_overflow(resp_overflow), .resp_zero(resp_zero), .resp_negative(resp_negative),
    .resp_err(resp_err), .busy_count(busy_count)
  );

  alu_arbiter #(.FAIR(1'b0)) dut_fixed (
    .clock(clk), .reset(rst),
    .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_A(req0_A), .req0_B(req0_B),
    .req0_control(req0_control),
    .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_A(req1_A), .req1_B(req1_B),
    .req1_control(req1_control),
    .resp_valid(f_resp_valid), .resp_ready(resp_ready), .resp_id(f_resp_id), .resp_out(f_resp_out),
    .resp_overflow(f_resp_overflow), .resp_zero(f_resp_zero), .resp_negative(f_resp_negative),
    .resp_err(f_resp_err), .busy_count(f_busy_count)
  );

  function automatic resp_t model(input logic id, input logic [31:0] a, input logic [31:0] b,
                                  input logic [2:0] c);
    resp_t  r;
    longint s;
    r = '0;
    r.id = id;
    case (c)
      3'd2: begin s = longint'($signed(a)) + longint'($signed(b)); r.out = s[31:0];
                  r.ov = (s != longint'($signed(r.out))); end
      3'd3: begin s = longint'($signed(a)) - longint'($signed(b)); r.out = s[31:0];
                  r.ov = (s != longint'($signed(r.out))); end
      3'd4: r.out = a & b;
      3'd5: r.out = a | b;
      3'd6: r.out = ~(a | b);
      3'd7: r.out = a ^ b;
      default: r.err = 1'b1;
    endcase
    r.z = !r.err && (r.out == 32'd0);
    r.n = r.out[31];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
    step();
    rst = 1'b0;
    m_valid = 1'b0; m_last = 1'b1; m_busy = 0;
    sb.delete();
  endtask

  // Drives one cycle of stimulus, predicts the grant for the round-robin instance and
  // pushes the predicted response for whichever request it expects to be accepted.
  task automatic drive(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [2:0] c0, input logic v1, input logic [31:0] a1,
                       input logic [31:0] b1, input logic [2:0] c1, input logic rr,
                       output logic g0, output logic g1);
    req0_valid = v0; req0_A = a0; req0_B = b0; req0_control = c0;
    req1_valid = v1; req1_A = a1; req1_B = b1; req1_control = c1;
    resp_ready = rr;
    #1;
    g0 = 1'b0; g1 = 1'b0;
    if (!m_valid || rr) begin
      if (v0 && v1) begin
        if (!m_last) g1 = 1'b1; else g0 = 1'b1;
      end else if (v0) g0 = 1'b1;
      else if (v1) g1 = 1'b1;
    end
    if (g0) sb.push_back(model(1'b0, a0, b0, c0));
    if (g1) sb.push_back(model(1'b1, a1, b1, c1));
    if (((v0 && !g0) || (v1 && !g1)) && m_busy < 255) m_busy++;
    if (g0 || g1) begin m_last = g1; m_valid = 1'b1; end
    else if (rr) m_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
    step();
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      miscompares++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
    end
    vectors++;
    if ({resp_valid, act, busy_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: valid=%b resp=%h busy=%0d want all zero", resp_valid, act, busy_count);
    end
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
    m_valid = 1'b0; m_last = 1'b1; m_busy = 0; sb.delete();
  endtask

  task automatic test_single_op();
    logic g0, g1;
    drive(1'b1, 32'd5, 32'd3, 3'd3, 1'b0, 32'd0, 32'd0, 3'd2, 1'b1, g0, g1);
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b10 || {g0, g1} !== 2'b10) begin
      miscompares++; $display("FAIL single_ready: got %b want 10", {req0_ready, req1_ready});
    end
    step();
    exp_r = sb.pop_front();
    vectors++;
    if (!resp_valid || act !== exp_r || resp_out !== 32'd2) begin
      miscompares++; $display("FAIL single_resp: got v=%b %h want %h", resp_valid, act, exp_r);
    end
  endtask

  task automatic test_flags();
    logic g0, g1;
    logic [31:0] a, b;
    logic [2:0] c;
    drive(1'b0, 32'd0, 32'd0, 3'd2, 1'b1, 32'h7FFF_FFFF, 32'd1, 3'd2, 1'b1, g0, g1);
    step();
    exp_r = sb.pop_front();
    vectors++;
    if (!resp_valid || act !== exp_r || {resp_id, resp_overflow, resp_negative} !== 3'b111) begin
      miscompares++; $display("FAIL flags_ovf: got v=%b %h want %h", resp_valid, act, exp_r);
    end
    drive(1'b1, 32'h1234, 32'h1234, 3'd3, 1'b0, 32'd0, 32'd0, 3'd2, 1'b1, g0, g1);
    step();
    exp_r = sb.pop_front();
    vectors++;
    if (!resp_valid || act !== exp_r || resp_zero !== 1'b1) begin
      miscompares++; $display("FAIL flags_zero: got v=%b %h want %h", resp_valid, act, exp_r);
    end
    for (int i = 0; i < 12; i++) begin
      a = $urandom; b = $urandom; c = 3'($urandom_range(7, 2));
      if (i % 3 == 0) b = a;
      drive(!i[0], a, b, c, i[0], a, b, c, 1'b1, g0, g1);
      step();
      exp_r = sb.pop_front();
      vectors++;
      if (!resp_valid || act !== exp_r) begin
        miscompares++; $display("FAIL flags_rand[%0d]: got %h want %h", i, act, exp_r);
      end
    end
  endtask

  task automatic test_contention_fair();
    logic g0, g1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i), 32'd7, 3'd2, 1'b1, 32'(i), 32'd7, 3'd7, 1'b1, g0, g1);
      vectors++;
      if ({req0_ready, req1_ready} !== {g0, g1}) begin
        miscompares++; $display("FAIL fair_ready[%0d]: got %b want %b", i, {req0_ready, req1_ready}, {g0, g1});
      end
      step();
      exp_r = sb.pop_front();
      vectors++;
      if (!resp_valid || act !== exp_r || resp_id !== (i % 2 == 1)) begin
        miscompares++; $display("FAIL fair_resp[%0d]: got %h want %h", i, act, exp_r);
      end
    end
    vectors++;
    if (busy_count !== 8'd4 || m_busy != 4) begin
      miscompares++; $display("FAIL fair_busy: got %0d want 4", busy_count);
    end
  endtask

  task automatic test_contention_fixed();
    logic g0, g1;
    resp_t fexp;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i * 3), 32'd9, 3'd3, 1'b1, 32'd1, 32'd1, 3'd2, 1'b1, g0, g1);
      fexp = model(1'b0, 32'(i * 3), 32'd9, 3'd3);
      vectors++;
      if ({f_req0_ready, f_req1_ready} !== 2'b10) begin
        miscompares++; $display("FAIL fixed_ready[%0d]: got %b want 10", i, {f_req0_ready, f_req1_ready});
      end
      step();
      exp_r = sb.pop_front();
      vectors++;
      if (!f_resp_valid || {f_resp_id, f_resp_out, f_resp_overflow, f_resp_zero, f_resp_negative,
                            f_resp_err} !== fexp) begin
        miscompares++; $display("FAIL fixed_resp[%0d]: got id=%b out=%h want %h", i, f_resp_id, f_resp_out, fexp);
      end
      vectors++;
      if (act !== exp_r) begin
        miscompares++; $display("FAIL fixed_fair_twin[%0d]: got %h want %h", i, act, exp_r);
      end
    end
    vectors++;
    if (f_busy_count !== 8'd4) begin
      miscompares++; $display("FAIL fixed_busy: got %0d want 4", f_busy_count);
    end
  endtask

  task automatic test_backpressure();
    logic g0, g1;
    do_reset();
    drive(1'b1, 32'hF0F0_0000, 32'h0F0F_FFFF, 3'd5, 1'b0, 32'd0, 32'd0, 3'd2, 1'b1, g0, g1);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'd1, 32'd2, 3'd2, 1'b1, 32'd3, 32'd4, 3'd4, 1'b0, g0, g1);
      vectors++;
      if ({req0_ready, req1_ready} !== 2'b00 || {g0, g1} !== 2'b00) begin
        miscompares++; $display("FAIL bp_ready[%0d]: got %b want 00", i, {req0_ready, req1_ready});
      end
      step();
      vectors++;
      if (!resp_valid || act !== sb[0]) begin
        miscompares++; $display("FAIL bp_hold[%0d]: got v=%b %h want %h", i, resp_valid, act, sb[0]);
      end
    end
    vectors++;
    if (busy_count !== 8'd3 || m_busy != 3) begin
      miscompares++; $display("FAIL bp_busy: got %0d want 3", busy_count);
    end
    drive(1'b0, 32'd0, 32'd0, 3'd2, 1'b1, 32'hAAAA_5555, 32'hFFFF_0000, 3'd6, 1'b1, g0, g1);
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      miscompares++; $display("FAIL bp_drain_accept: got %b want 01", {req0_ready, req1_ready});
    end
    exp_r = sb.pop_front();
    step();
    exp_r = sb.pop_front();
    vectors++;
    if (!resp_valid || act !== exp_r) begin
      miscompares++; $display("FAIL bp_new_resp: got %h want %h", act, exp_r);
    end
    drive(1'b0, 32'd0, 32'd0, 3'd2, 1'b0, 32'd0, 32'd0, 3'd2, 1'b1, g0, g1);
    step();
    vectors++;
    if (resp_valid !== 1'b0 || act !== exp_r) begin
      miscompares++; $display("FAIL bp_idle_drain: got v=%b %h want v=0 %h", resp_valid, act, exp_r);
    end
  endtask

  task automatic test_busy_saturate();
    logic g0, g1;
    do_reset();
    drive(1'b1, 32'd1, 32'd1, 3'd2, 1'b0, 32'd0, 32'd0, 3'd2, 1'b1, g0, g1);
    step();
    for (int i = 0; i < 260; i++) begin
      drive(1'b1, 32'd1, 32'd1, 3'd2, 1'b0, 32'd0, 32'd0, 3'd2, 1'b0, g0, g1);
      step();
    end
    vectors++;
    if (busy_count !== 8'd255 || m_busy != 255) begin
      miscompares++; $display("FAIL busy_saturate: got %0d want 255", busy_count);
    end
  endtask

  task automatic test_illegal_reset();
    logic g0, g1;
    do_reset();
    drive(1'b1, 32'hDEAD_BEEF, 32'h1, 3'd1, 1'b0, 32'd0, 32'd0, 3'd2, 1'b1, g0, g1);
    step();
    exp_r = sb.pop_front();
    vectors++;
    if (!resp_valid || act !== exp_r || resp_err !== 1'b1 || resp_out !== 32'd0) begin
      miscompares++; $display("FAIL illegal_c1: got %h want %h", act, exp_r);
    end
    drive(1'b1, 32'd4, 32'd4, 3'd2, 1'b1, 32'd0, 32'd0, 3'd0, 1'b1, g0, g1);
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      miscompares++; $display("FAIL illegal_rr: got %b want 01", {req0_ready, req1_ready});
    end
    step();
    exp_r = sb.pop_front();
    vectors++;
    if (!resp_valid || act !== exp_r || {resp_err, resp_zero} !== 2'b10) begin
      miscompares++; $display("FAIL illegal_c0: got %h want %h", act, exp_r);
    end
    drive(1'b1, 32'd4, 32'd4, 3'd2, 1'b1, 32'd0, 32'd0, 3'd0, 1'b0, g0, g1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_valid = 1'b0; m_last = 1'b1; m_busy = 0; sb.delete();
    vectors++;
    if (resp_valid !== 1'b0 || busy_count !== 8'd0) begin
      miscompares++; $display("FAIL reset_mid: got v=%b busy=%0d want 0 0", resp_valid, busy_count);
    end
    drive(1'b1, 32'd8, 32'd2, 3'd3, 1'b1, 32'd0, 32'd0, 3'd2, 1'b1, g0, g1);
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      miscompares++; $display("FAIL reset_prio: got %b want 10", {req0_ready, req1_ready});
    end
    step();
    exp_r = sb.pop_front();
    vectors++;
    if (!resp_valid || act !== exp_r || resp_out !== 32'd6) begin
      miscompares++; $display("FAIL reset_after: got %h want %h", act, exp_r);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #2;
    test_reset();
    test_single_op();
    test_flags();
    test_contention_fair();
    test_contention_fixed();
    test_backpressure();
    test_busy_saturate();
    test_illegal_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
